// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared constants for the 4x4 keypad scanner: matrix geometry, the width of
// the key-state vector, the column-state encoding and the rule that maps a
// (row, column) position onto a bit of the key-state vector.
// -----------------------------------------------------------------------------
package keypad_pkg;

  localparam int kRows     = 4;
  localparam int kCols     = 4;
  localparam int kKeyWidth = kRows * kCols;

  // Column currently being driven low.
  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } col_e;

  // Key (r, c) lives at bit r*kCols + c of the key-state vector.
  function automatic int key_idx(input int r, input int c);
    return r * kCols + c;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Generic two-flop synchronizer for bringing asynchronous level signals into
// the clk domain.
//   i_clk    : destination clock
//   i_rst_n  : asynchronous active-low reset
//   i_d      : asynchronous input, kWidth bits
//   o_q      : synchronized output, two clk edges behind i_d
// kRstVal sets the value both stages take in reset, so a bus that idles high
// (pulled-up rows) does not look active while the chip comes out of reset.
// -----------------------------------------------------------------------------
module sync2 #(
  parameter int                kWidth  = 1,
  parameter logic [kWidth-1:0] kRstVal = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [kWidth-1:0] i_d,
  output logic [kWidth-1:0] o_q
);

  logic [kWidth-1:0] r_meta;
  logic [kWidth-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= kRstVal;
      r_sync <= kRstVal;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 passive key matrix one column at a time, synchronizes the row
// returns, assembles a full-matrix frame every 4*kScanDiv cycles and debounces
// it: the key-state output only moves after kDebounceFrames identical
// consecutive frames, and only at a frame end, so readers always see a
// whole-frame-consistent vector.
//   clk         : system clock, rising edge
//   rst         : asynchronous active-low reset
//   row_in      : matrix rows, active-low, asynchronous to clk
//   col_out     : column drive, active-low, one-cold
//   keypad      : debounced key state, bit r*4+c set = key (r,c) pressed
//   key_changed : one-cycle pulse in the cycle keypad takes a new value
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int kScanDiv        = 1000,
  parameter int kDebounceFrames = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [kRows-1:0]     row_in,
  output logic [kCols-1:0]     col_out,
  output logic [kKeyWidth-1:0] keypad,
  output logic                 key_changed
);

  localparam int                kCntW    = $clog2(kScanDiv);
  localparam logic [kCntW-1:0]  kCntLast = kCntW'(kScanDiv - 1);
  localparam int                kStW     = $clog2(kDebounceFrames + 1);
  localparam logic [kStW-1:0]   kStMax   = kStW'(kDebounceFrames);
  localparam logic [kStW-1:0]   kStOne   = kStW'(1);

  logic [kRows-1:0]     w_row_q;
  logic [kRows-1:0]     w_row_s;
  logic                 w_sample;
  logic                 w_frame_end;
  col_e                 w_col_nxt;
  logic [kKeyWidth-1:0] w_full;
  logic [kStW-1:0]      w_new_cnt;

  logic [kCntW-1:0]     r_cnt;
  col_e                 r_col;
  logic [kCols-1:0]     r_col_out;
  logic [kKeyWidth-1:0] r_frame;
  logic [kKeyWidth-1:0] r_cand;
  logic [kStW-1:0]      r_stable;
  logic [kKeyWidth-1:0] r_keypad;
  logic                 r_changed;

  // Rows idle high, so the synchronizer resets to all-ones (nothing pressed).
  sync2 #(
    .kWidth  (kRows),
    .kRstVal ({kRows{1'b1}})
  ) u_row_sync (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_d     (row_in),
    .o_q     (w_row_q)
  );

  // Internally a 1 means pressed.
  assign w_row_s     = ~w_row_q;
  // Sampling on the last dwell cycle gives the column time to settle and the
  // synchronizer time to carry the settled rows through.
  assign w_sample    = (r_cnt == kCntLast);
  assign w_frame_end = w_sample && (r_col == COL3);
  assign w_col_nxt   = col_e'(r_col + 2'd1);

  // The column-3 bits are only being captured this cycle, so the frame under
  // comparison takes them straight from the synchronizer.
  always_comb begin
    w_full = r_frame;
    for (int r = 0; r < kRows; r++) begin
      w_full[key_idx(r, kCols - 1)] = w_row_s[r];
    end
  end

  always_comb begin
    w_new_cnt = kStOne;
    if (w_full == r_cand) begin
      w_new_cnt = (r_stable >= kStMax) ? kStMax : r_stable + kStOne;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_col     <= COL0;
      r_col_out <= 4'b1110;
      r_frame   <= '0;
      r_cand    <= '0;
      r_stable  <= '0;
      r_keypad  <= '0;
      r_changed <= 1'b0;
    end else begin
      r_changed <= 1'b0;
      if (w_sample) begin
        r_cnt     <= '0;
        r_col     <= w_col_nxt;
        r_col_out <= ~(4'b0001 << w_col_nxt);
        for (int r = 0; r < kRows; r++) begin
          r_frame[key_idx(r, int'(r_col))] <= w_row_s[r];
        end
        if (w_frame_end) begin
          // When the frame matches the candidate, w_full already equals it.
          r_cand   <= w_full;
          r_stable <= w_new_cnt;
          if ((w_new_cnt == kStMax) && (w_full != r_keypad)) begin
            r_keypad  <= w_full;
            r_changed <= 1'b1;
          end
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign col_out     = r_col_out;
  assign keypad      = r_keypad;
  assign key_changed = r_changed;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Drives a modelled 4x4 key matrix into keypad_scanner (kScanDiv=4,
// kDebounceFrames=3) and checks every cycle against a frame-level model of
// the scan / debounce rules, plus hand-computed expectations for the
// directed scenarios.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int kDiv = 4;
  localparam int kDeb = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] keypad;
  logic        key_changed;

  logic [15:0] keys = 16'h0000;

  int checks = 0;
  int errors = 0;

  // Model state.
  int          n;
  logic [3:0]  hist [4];
  logic [15:0] m_frame;
  logic [15:0] m_cand;
  int          m_cnt;
  logic [15:0] m_keypad;
  logic        m_chg;
  int          pulses;
  bit          saw80;

  always #5 clk = ~clk;

  // Passive matrix: row r is pulled low when a pressed key in that row sits
  // on a column currently driven low.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
    end
  end

  keypad_scanner #(
    .kScanDiv        (kDiv),
    .kDebounceFrames (kDeb)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row_in      (row_in),
    .col_out     (col_out),
    .keypad      (keypad),
    .key_changed (key_changed)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got %h expected %h", name, n, act, exp);
    end
  endtask

  task automatic reset_model();
    n        = 0;
    m_frame  = '0;
    m_cand   = '0;
    m_cnt    = 0;
    m_keypad = '0;
    m_chg    = 1'b0;
    for (int i = 0; i < 4; i++) hist[i] = 4'hF;
  endtask

  // Edge n samples column (n/4)%4 when n%4==3, seeing the rows that were
  // present two edges earlier (synchronizer delay).
  task automatic model_edge();
    int c;
    logic [3:0] rows;
    m_chg = 1'b0;
    if (n % kDiv == kDiv - 1) begin
      c    = (n / kDiv) % 4;
      rows = hist[(n + 2) % 4];
      for (int r = 0; r < 4; r++) m_frame[r*4 + c] = ~rows[r];
      if (c == 3) begin
        if (m_frame != m_cand) begin
          m_cand = m_frame;
          m_cnt  = 1;
        end else if (m_cnt < kDeb) begin
          m_cnt++;
        end
        if (m_cnt == kDeb && m_cand != m_keypad) begin
          m_keypad = m_cand;
          m_chg    = 1'b1;
        end
      end
    end
  endtask

  // One clock: record the rows seen by the coming edge, then compare outputs.
  task automatic step();
    int         c;
    logic [3:0] exp_col;
    @(negedge clk);
    hist[n % 4] = row_in;
    @(posedge clk);
    #1;
    model_edge();
    c       = ((n + 1) / kDiv) % 4;
    exp_col = 4'hF ^ (4'h1 << c);
    check("col_out", {28'd0, col_out}, {28'd0, exp_col});
    check("keypad", {16'd0, keypad}, {16'd0, m_keypad});
    check("key_changed", {31'd0, key_changed}, {31'd0, m_chg});
    if (key_changed) pulses++;
    if (keypad == 16'h0080) saw80 = 1'b1;
    n++;
  endtask

  task automatic align();
    while (n % (4 * kDiv) != 0) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout edge=%0d", n);
    $fatal(1, "timeout");
  end

  initial begin
    reset_model();
    pulses = 0;
    saw80  = 1'b0;

    // 1. Reset values.
    repeat (3) @(posedge clk);
    #2;
    check("rst col_out", {28'd0, col_out}, 32'hE);
    check("rst keypad", {16'd0, keypad}, 32'h0);
    check("rst key_changed", {31'd0, key_changed}, 32'h0);
    rst = 1'b1;
    reset_model();

    // 2. Idle matrix for 3 frames.
    repeat (48) step();
    check("idle keypad", {16'd0, keypad}, 32'h0);
    check("idle pulses", pulses, 0);

    // 3. Key (2,1) held from a frame start.
    align();
    keys   = 16'h0200;
    pulses = 0;
    repeat (47) step();
    check("press early keypad", {16'd0, keypad}, 32'h0);
    step();
    check("press keypad", {16'd0, keypad}, 32'h0200);
    check("press pulse", {31'd0, key_changed}, 32'h1);
    step();
    check("press pulse end", {31'd0, key_changed}, 32'h0);
    repeat (16) step();
    check("press pulses", pulses, 1);

    // Asynchronous reset mid-frame, no clock edge in between.
    #3;
    rst = 1'b0;
    #1;
    check("async col_out", {28'd0, col_out}, 32'hE);
    check("async keypad", {16'd0, keypad}, 32'h0);
    check("async key_changed", {31'd0, key_changed}, 32'h0);
    keys = 16'h0000;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    reset_model();

    // 4. Key (2,1) alternating every frame: never stable long enough.
    align();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      repeat (16) step();
    end
    check("bounce keypad", {16'd0, keypad}, 32'h0);
    check("bounce pulses", pulses, 0);

    // 5. Keys (0,0) and (3,3) together, then released.
    align();
    keys   = 16'h8001;
    pulses = 0;
    repeat (48) step();
    check("pair keypad", {16'd0, keypad}, 32'h8001);
    keys = 16'h0000;
    repeat (48) step();
    check("pair release keypad", {16'd0, keypad}, 32'h0);
    check("pair pulses", pulses, 2);

    // 6. (1,3) for only 2 frames, then (1,2) for 3 frames.
    align();
    keys   = 16'h0080;
    pulses = 0;
    saw80  = 1'b0;
    repeat (32) step();
    keys = 16'h0040;
    repeat (48) step();
    check("short key never shown", {31'd0, saw80}, 32'h0);
    check("switch keypad", {16'd0, keypad}, 32'h0040);
    check("switch pulses", pulses, 1);

    // Randomized holds and bounces against the model.
    for (int i = 0; i < 80; i++) begin
      keys = 16'($urandom) & 16'($urandom) & 16'($urandom);
      repeat ($urandom_range(1, 70)) step();
    end
    keys = 16'h0000;
    repeat (64) step();
    check("final keypad", {16'd0, keypad}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
